mmss_updown_timer: RTL and testbench
====================================

# mmss_updown_timer

Parametrised minutes:seconds timer producing four seven-segment digits (MM:SS). Successor to the single-digit-pair seconds counter: prescaler, up/down modes, BCD preset load, lap (display freeze) and an expiry flag, all in one clock domain with clock enables (no ripple clocks). Drives HEX3..HEX0 on the lab board; the prescaler divides the board clock to 1 Hz.

## Interface
- CLK_DIV, 50_000_000, board clocks per count step (≥2)
- MAX_MIN, 59, highest minute value (1..99); minute wrap/clamp point
- SEG_ACTIVE_LOW, 1, 1: segment lit = 0; 0: lit = 1

- clock_sig  in  1  system clock
- reset_sig  in  1  asynchronous, active-high reset
- OnOff_sig  in  1  level; 1 = run, 0 = stop (value held)
- mode_sig  in  1  0 = count up, 1 = count down
- load_sig  in  1  one-cycle pulse; preset counter from load_min/load_sec
- load_min  in  8  BCD minutes {tens,units}
- load_sec  in  8  BCD seconds {tens,units}
- lap_sig  in  1  one-cycle pulse; toggle display freeze
- hex0, hex1, hex2, hex3  out  7 each  seconds units, seconds tens, minutes units, minutes tens; bit0=a … bit6=g
- tick_sig  out  1  one-cycle pulse on each count step
- wrap_sig  out  1  one-cycle pulse on up-count wrap MAX_MIN:59 → 00:00
- done_sig  out  1  level; high in EXPIRED

## Operation
- Registers: prescaler [ceil(log2 CLK_DIV)-1:0], BCD digits s0 (0-9), s1 (0-5), m0 (0-9), m1 (0-9), hold digits, hold flag, state.
- States: STOPPED, RUNNING, EXPIRED.
  - STOPPED → RUNNING when OnOff_sig=1 and not (mode_sig=1 and count=00:00).
  - RUNNING → STOPPED when OnOff_sig=0; prescaler holds its value.
  - RUNNING → EXPIRED on a down step that produces 00:00.
  - EXPIRED → STOPPED on load_sig, or mode_sig=0; only reset otherwise leaves it.
- Prescaler increments only in RUNNING; at CLK_DIV-1 it returns to 0 and a step occurs (tick_sig=1).
- Up step: BCD ripple s0→s1 (wrap at 59)→minutes; MAX_MIN:59 → 00:00 with wrap_sig.
- Down step: BCD borrow; at 00:00 no step occurs in RUNNING (state is already EXPIRED).
- Load: digits ← load values; prescaler ← 0; any digit >9, seconds tens >5 or minutes >MAX_MIN saturates whole field to its max (59 or MAX_MIN). Load accepted in any state.
- Lap: pulse toggles hold flag; on set, hold digits capture the current (pre-edge) count. Displays show hold digits while hold=1, live digits otherwise. Counter keeps running. Load clears hold.
- Decoder: digits 0-9 standard patterns (0=abcdef, 1=bc, 7=abc, 9=abcdfg); inverted when SEG_ACTIVE_LOW=1.

## Timing
- Reset (async assert, sync release): count 00:00, prescaler 0, STOPPED, hold 0; tick_sig/wrap_sig/done_sig 0; hex outputs show "0000" (active-low 7'b1000000 each).
- Digits update on the clock edge where prescaler=CLK_DIV-1; tick_sig/wrap_sig registered, high for the following cycle, aligned with the new digit values.
- First step after start: exactly CLK_DIV RUNNING cycles after OnOff_sig sampled high (from prescaler 0).
- hex outputs combinational from registered digits: valid same cycle as the digit update.
- done_sig rises the cycle the count reaches 00:00.
- Priority per edge: reset > load > step > lap. Load and step in same cycle: load wins, no tick_sig. Lap and step in same cycle: hold captures pre-step value.
- mode_sig change takes effect on the next step; no prescaler reset.

## Test plan
- CLK_DIV=4, reset, OnOff=1 up: after 4 cycles tick_sig, display 00:01; at 240 cycles 01:00.
- Load 59:58 (MAX_MIN=59), up, run 8 cycles → 59:59 then 00:00 with one wrap_sig pulse.
- Load 00:02, mode=1, run → 00:01, 00:00, done_sig=1, STOPPED only after load; further cycles no tick.
- Load 7'h?: load_sec=8'h75, load_min=8'h12 → reads 12:59; load_min=8'hA0 → 59:xx.
- Lap at 00:03, run 12 cycles → hex shows 00:03, live 00:06; second lap → shows 00:06.
- Reset asserted mid-count (between clock edges) → all outputs to reset values immediately; OnOff=0 mid-prescale then 1 → step after remaining cycles only.

Source files
------------

// File: rtl/mmss_updown_timer_if.sv
// Control inputs and display/status outputs of the MM:SS up/down timer.
interface mmss_updown_timer_if;
    logic       OnOff_sig;
    logic       mode_sig;
    logic       load_sig;
    logic [7:0] load_min;
    logic [7:0] load_sec;
    logic       lap_sig;
    logic [6:0] hex0;
    logic [6:0] hex1;
    logic [6:0] hex2;
    logic [6:0] hex3;
    logic       tick_sig;
    logic       wrap_sig;
    logic       done_sig;

    modport master (
        output OnOff_sig, mode_sig, load_sig, load_min, load_sec, lap_sig,
        input  hex0, hex1, hex2, hex3, tick_sig, wrap_sig, done_sig
    );

    modport slave (
        input  OnOff_sig, mode_sig, load_sig, load_min, load_sec, lap_sig,
        output hex0, hex1, hex2, hex3, tick_sig, wrap_sig, done_sig
    );
endinterface

// File: rtl/mmss_updown_timer.sv
// MM:SS up/down timer: prescaled BCD counter with preset load, lap freeze,
// expiry flag and four seven-segment digit outputs. Single clock domain.
module mmss_updown_timer #(
    parameter int CLK_DIV        = 50_000_000,
    parameter int MAX_MIN        = 59,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                clock_sig,
    input  logic                reset_sig,
    mmss_updown_timer_if.slave  bus
);
    localparam int              PW       = $clog2(CLK_DIV);
    localparam logic [PW-1:0]   PRE_LAST = PW'(CLK_DIV - 1);
    localparam logic [3:0]      MAX_M1   = 4'(MAX_MIN / 10);
    localparam logic [3:0]      MAX_M0   = 4'(MAX_MIN % 10);

    typedef enum logic [1:0] {STOPPED, RUNNING, EXPIRED} state_t;
    typedef struct packed {
        logic [3:0] m1;
        logic [3:0] m0;
        logic [3:0] s1;
        logic [3:0] s0;
    } mmss_t;

    state_t        state, state_nxt;
    logic [PW-1:0] presc;
    mmss_t         cnt, cnt_up, cnt_dn, cnt_ld, hcnt, disp;
    logic          hold, tick_q, wrap_q;
    logic          run_en, pre_last, is_zero, is_one, at_max, step;
    logic [7:0]    ld_min_val;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'h3F;
            4'd1:    p = 7'h06;
            4'd2:    p = 7'h5B;
            4'd3:    p = 7'h4F;
            4'd4:    p = 7'h66;
            4'd5:    p = 7'h6D;
            4'd6:    p = 7'h7D;
            4'd7:    p = 7'h07;
            4'd8:    p = 7'h7F;
            4'd9:    p = 7'h6F;
            default: p = 7'h00;
        endcase
        return SEG_ACTIVE_LOW ? ~p : p;
    endfunction

    // Step qualification; a down step from 00:00 is suppressed, load pre-empts a step.
    always_comb begin
        run_en   = (state == RUNNING) && bus.OnOff_sig;
        pre_last = (presc == PRE_LAST);
        is_zero  = (cnt == 16'h0000);
        is_one   = (cnt == 16'h0001);
        at_max   = (cnt == {MAX_M1, MAX_M0, 4'd5, 4'd9});
        step     = run_en && pre_last && !bus.load_sig && !(bus.mode_sig && is_zero);
    end

    // Next count for an up step: BCD ripple with MAX_MIN:59 -> 00:00 wrap.
    always_comb begin
        cnt_up = cnt;
        if (at_max) begin
            cnt_up = '0;
        end else if (cnt.s0 != 4'd9) begin
            cnt_up.s0 = cnt.s0 + 4'd1;
        end else begin
            cnt_up.s0 = 4'd0;
            if (cnt.s1 != 4'd5) begin
                cnt_up.s1 = cnt.s1 + 4'd1;
            end else begin
                cnt_up.s1 = 4'd0;
                if (cnt.m0 != 4'd9) begin
                    cnt_up.m0 = cnt.m0 + 4'd1;
                end else begin
                    cnt_up.m0 = 4'd0;
                    cnt_up.m1 = cnt.m1 + 4'd1;
                end
            end
        end
    end

    // Next count for a down step: BCD borrow chain (never used from 00:00).
    always_comb begin
        cnt_dn = cnt;
        if (cnt.s0 != 4'd0) begin
            cnt_dn.s0 = cnt.s0 - 4'd1;
        end else begin
            cnt_dn.s0 = 4'd9;
            if (cnt.s1 != 4'd0) begin
                cnt_dn.s1 = cnt.s1 - 4'd1;
            end else begin
                cnt_dn.s1 = 4'd5;
                if (cnt.m0 != 4'd0) begin
                    cnt_dn.m0 = cnt.m0 - 4'd1;
                end else begin
                    cnt_dn.m0 = 4'd9;
                    cnt_dn.m1 = cnt.m1 - 4'd1;
                end
            end
        end
    end

    // Preset value; an out-of-range field saturates as a whole to its maximum.
    always_comb begin
        cnt_ld     = {bus.load_min, bus.load_sec};
        ld_min_val = 8'(bus.load_min[7:4]) * 8'd10 + 8'(bus.load_min[3:0]);
        if (bus.load_sec[7:4] > 4'd5 || bus.load_sec[3:0] > 4'd9) begin
            cnt_ld.s1 = 4'd5;
            cnt_ld.s0 = 4'd9;
        end
        if (bus.load_min[7:4] > 4'd9 || bus.load_min[3:0] > 4'd9 ||
            ld_min_val > 8'(MAX_MIN)) begin
            cnt_ld.m1 = MAX_M1;
            cnt_ld.m0 = MAX_M0;
        end
    end

    // Datapath: prescaler, count, lap hold and registered step pulses.
    always_ff @(posedge clock_sig or posedge reset_sig) begin
        if (reset_sig) begin
            presc  <= '0;
            cnt    <= '0;
            hcnt   <= '0;
            hold   <= 1'b0;
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            tick_q <= step;
            wrap_q <= step && !bus.mode_sig && at_max;
            if (bus.load_sig) begin
                cnt   <= cnt_ld;
                presc <= '0;
                hold  <= 1'b0;
            end else begin
                if (run_en)
                    presc <= pre_last ? '0 : presc + PW'(1);
                if (step)
                    cnt <= bus.mode_sig ? cnt_dn : cnt_up;
                // Capture uses the pre-edge count, so a coincident step is not seen.
                if (bus.lap_sig) begin
                    hold <= !hold;
                    if (!hold)
                        hcnt <= cnt;
                end
            end
        end
    end

    // State register.
    always_ff @(posedge clock_sig or posedge reset_sig) begin
        if (reset_sig) state <= STOPPED;
        else           state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            STOPPED: if (bus.OnOff_sig && !(bus.mode_sig && is_zero)) state_nxt = RUNNING;
            RUNNING: begin
                if (!bus.OnOff_sig)                       state_nxt = STOPPED;
                else if (step && bus.mode_sig && is_one) state_nxt = EXPIRED;
            end
            EXPIRED: if (bus.load_sig || !bus.mode_sig) state_nxt = STOPPED;
            default: state_nxt = STOPPED;
        endcase
    end

    // Outputs: decoded display (held or live) and status flags.
    always_comb begin
        disp         = hold ? hcnt : cnt;
        bus.hex0     = seg7(disp.s0);
        bus.hex1     = seg7(disp.s1);
        bus.hex2     = seg7(disp.m0);
        bus.hex3     = seg7(disp.m1);
        bus.tick_sig = tick_q;
        bus.wrap_sig = wrap_q;
        bus.done_sig = (state == EXPIRED);
    end
endmodule

// File: tb/tb_mmss_updown_timer.sv
// Scoreboard bench: a seconds-based reference model pushes expected outputs
// for each edge; the DUT outputs are popped and compared after the edge.
module tb_mmss_updown_timer;
    localparam int CLK_DIV = 4;
    localparam int MAX_MIN = 59;
    localparam int TOT     = (MAX_MIN + 1) * 60;

    logic clock_sig = 1'b0;
    logic reset_sig = 1'b1;
    mmss_updown_timer_if tif();

    mmss_updown_timer #(.CLK_DIV(CLK_DIV), .MAX_MIN(MAX_MIN), .SEG_ACTIVE_LOW(1'b1)) dut (
        .clock_sig(clock_sig),
        .reset_sig(reset_sig),
        .bus(tif)
    );

    always #5 clock_sig = ~clock_sig;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] sb[$];

    // model state: 0 stopped, 1 running, 2 expired
    int m_cnt, m_presc, m_st, m_hold, m_hcnt, m_tk, m_wr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [6:0] seg(input int d);
        logic [6:0] p;
        case (d)
            0: p = 7'h3F; 1: p = 7'h06; 2: p = 7'h5B; 3: p = 7'h4F; 4: p = 7'h66;
            5: p = 7'h6D; 6: p = 7'h7D; 7: p = 7'h07; 8: p = 7'h7F; 9: p = 7'h6F;
            default: p = 7'h00;
        endcase
        return ~p;
    endfunction

    function automatic logic [31:0] exp_vec();
        int d, s, m;
        d = m_hold ? m_hcnt : m_cnt;
        s = d % 60;
        m = d / 60;
        return {1'b0, (m_st == 2), m_wr[0], m_tk[0], seg(m / 10), seg(m % 10), seg(s / 10), seg(s % 10)};
    endfunction

    function automatic logic [31:0] obs_vec();
        return {1'b0, tif.done_sig, tif.wrap_sig, tif.tick_sig, tif.hex3, tif.hex2, tif.hex1, tif.hex0};
    endfunction

    function automatic int sat_load(input logic [7:0] lm, input logic [7:0] ls);
        int s, m;
        if (ls[7:4] > 5 || ls[3:0] > 9) s = 59;
        else s = int'(ls[7:4]) * 10 + int'(ls[3:0]);
        m = int'(lm[7:4]) * 10 + int'(lm[3:0]);
        if (lm[7:4] > 9 || lm[3:0] > 9 || m > MAX_MIN) m = MAX_MIN;
        return m * 60 + s;
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_presc = 0; m_st = 0; m_hold = 0; m_hcnt = 0; m_tk = 0; m_wr = 0;
    endtask

    task automatic model_edge();
        int  ncnt, npresc, nst, nhold, nhcnt, ntk, nwr;
        bit  stepping, run;
        ncnt = m_cnt; npresc = m_presc; nst = m_st; nhold = m_hold; nhcnt = m_hcnt; ntk = 0; nwr = 0;
        run      = (m_st == 1) && tif.OnOff_sig;
        stepping = run && (m_presc == CLK_DIV - 1) && !tif.load_sig && !(tif.mode_sig && m_cnt == 0);
        if (tif.load_sig) begin
            ncnt = sat_load(tif.load_min, tif.load_sec);
            npresc = 0;
            nhold = 0;
        end else begin
            if (run) npresc = (m_presc == CLK_DIV - 1) ? 0 : m_presc + 1;
            if (stepping) begin
                ntk = 1;
                if (tif.mode_sig) ncnt = m_cnt - 1;
                else if (m_cnt == TOT - 1) begin ncnt = 0; nwr = 1; end
                else ncnt = m_cnt + 1;
            end
            if (tif.lap_sig) begin
                nhold = m_hold ? 0 : 1;
                if (m_hold == 0) nhcnt = m_cnt;
            end
        end
        case (m_st)
            0: if (tif.OnOff_sig && !(tif.mode_sig && m_cnt == 0)) nst = 1;
            1: if (!tif.OnOff_sig) nst = 0;
               else if (stepping && tif.mode_sig && m_cnt == 1) nst = 2;
            default: if (tif.load_sig || !tif.mode_sig) nst = 0;
        endcase
        m_cnt = ncnt; m_presc = npresc; m_st = nst; m_hold = nhold; m_hcnt = nhcnt; m_tk = ntk; m_wr = nwr;
    endtask

    // One clock: predict, push, let the edge happen, pop and compare.
    task automatic cyc();
        model_edge();
        sb.push_back(exp_vec());
        @(posedge clock_sig);
        #1;
        chk("sb", obs_vec(), sb.pop_front());
    endtask

    task automatic load(input logic [7:0] lm, input logic [7:0] ls);
        tif.load_min = lm; tif.load_sec = ls; tif.load_sig = 1'b1;
        cyc();
        tif.load_sig = 1'b0;
    endtask

    initial begin
        int wraps, n;
        tif.OnOff_sig = 0; tif.mode_sig = 0; tif.load_sig = 0; tif.lap_sig = 0;
        tif.load_min = 0; tif.load_sec = 0;
        model_reset();
        repeat (2) @(posedge clock_sig);
        #1;
        sb.push_back(exp_vec());
        chk("reset", obs_vec(), sb.pop_front());
        chk("reset_hex0", 32'(tif.hex0), 32'(7'b1000000));
        reset_sig = 1'b0;

        // up count from 00:00
        tif.OnOff_sig = 1;
        cyc();
        repeat (4) cyc();
        chk("first_tick", 32'({tif.tick_sig, tif.hex0}), 32'({1'b1, 7'b1111001}));
        repeat (236) cyc();
        chk("one_min", 32'({tif.hex3, tif.hex2, tif.hex1, tif.hex0}),
            32'({7'b1000000, 7'b1111001, 7'b1000000, 7'b1000000}));

        // wrap at MAX_MIN:59
        load(8'h59, 8'h58);
        wraps = 0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            wraps += int'(tif.wrap_sig);
        end
        chk("wrap_cnt", 32'(wraps), 32'd1);

        // down count to expiry
        tif.mode_sig = 1;
        load(8'h00, 8'h02);
        repeat (12) cyc();
        chk("done", 32'(tif.done_sig), 32'd1);
        tif.OnOff_sig = 0;
        load(8'h00, 8'h05);
        chk("done_clr", 32'(tif.done_sig), 32'd0);
        repeat (2) cyc();

        // load saturation
        tif.mode_sig = 0;
        load(8'h12, 8'h75);
        chk("sat_sec", 32'({tif.hex3, tif.hex2, tif.hex1, tif.hex0}),
            32'({7'b1111001, 7'b0100100, 7'b0010010, 7'b0010000}));
        load(8'hA0, 8'h30);
        chk("sat_min", 32'({tif.hex3, tif.hex2}), 32'({7'b0010010, 7'b0010000}));

        // lap freeze
        load(8'h00, 8'h03);
        tif.OnOff_sig = 1; tif.lap_sig = 1;
        cyc();
        tif.lap_sig = 0;
        repeat (12) cyc();
        chk("lap_hold", 32'({tif.hex3, tif.hex2, tif.hex1, tif.hex0}),
            32'({7'b1000000, 7'b1000000, 7'b1000000, 7'b0110000}));
        tif.lap_sig = 1;
        cyc();
        tif.lap_sig = 0;
        chk("lap_live", 32'({tif.hex3, tif.hex2, tif.hex1, tif.hex0}),
            32'({7'b1000000, 7'b1000000, 7'b1000000, 7'b0000010}));
        repeat (3) cyc();

        // asynchronous reset between edges
        #3;
        reset_sig = 1'b1;
        #1;
        model_reset();
        sb.push_back(exp_vec());
        chk("async_rst", obs_vec(), sb.pop_front());
        tif.OnOff_sig = 0; tif.mode_sig = 0;
        #2;
        reset_sig = 1'b0;

        // stop mid-prescale, resume: only the remaining cycles are needed
        tif.OnOff_sig = 1;
        repeat (3) cyc();
        tif.OnOff_sig = 0;
        repeat (3) cyc();
        tif.OnOff_sig = 1;
        cyc();
        n = 0;
        do begin
            cyc();
            n++;
        end while (!tif.tick_sig && n < 10);
        chk("resume_len", 32'(n), 32'd2);

        // random mix against the model
        for (int i = 0; i < 400; i++) begin
            tif.OnOff_sig = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 49) == 0) tif.mode_sig = ~tif.mode_sig;
            tif.lap_sig  = ($urandom_range(0, 19) == 0);
            tif.load_sig = ($urandom_range(0, 39) == 0);
            tif.load_min = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
            tif.load_sec = 8'($urandom_range(0, 3));
            cyc();
        end
        tif.load_sig = 0; tif.lap_sig = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
